// File: rtl/pong_game_sequencer_if.sv
// Signal bundle between the Pong game-flow sequencer and the position datapath / score display.
// master = the sequencer, slave = the datapath side that supplies misses and consumes strobes.
interface pong_game_sequencer_if;
    logic       start;
    logic       pause;
    logic       miss_left;
    logic       miss_right;
    logic       move_tick;
    logic       ball_reset;
    logic       paddle_reset;
    logic       serve_dir;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       game_over;
    logic       winner;
    logic [1:0] state;

    modport master (
        input  start, pause, miss_left, miss_right,
        output move_tick, ball_reset, paddle_reset, serve_dir,
               p1_score, p2_score, game_over, winner, state
    );

    modport slave (
        output start, pause, miss_left, miss_right,
        input  move_tick, ball_reset, paddle_reset, serve_dir,
               p1_score, p2_score, game_over, winner, state
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: movement strobe, idle/serve/play/over sequencing, scores,
// and ball/paddle re-centre pulses. Single clock domain, every output registered.
module pong_game_sequencer #(
    parameter int unsigned TICK_DIV    = 1048576,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned WIN_SCORE   = 10
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    pong_game_sequencer_if.master  bus
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } phase_t;

    phase_t        st;
    logic [CW-1:0] tick_cnt;
    logic [7:0]    hold;
    logic          start_d;
    logic          move_tick_q;
    logic          ball_reset_q;
    logic          paddle_reset_q;
    logic          serve_dir_q;
    logic [3:0]    p1_q;
    logic [3:0]    p2_q;
    logic          game_over_q;
    logic          winner_q;

    logic       tick;
    logic       start_edge;
    logic       hold_last;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    always_comb begin
        tick       = (tick_cnt == CW'(TICK_DIV - 1));
        start_edge = bus.start & ~start_d;
        hold_last  = (hold == 8'(SERVE_TICKS - 1));
        p1_inc     = p1_q + 4'd1;
        p2_inc     = p2_q + 4'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st             <= IDLE;
            hold           <= '0;
            start_d        <= 1'b0;
            move_tick_q    <= 1'b0;
            ball_reset_q   <= 1'b0;
            paddle_reset_q <= 1'b0;
            serve_dir_q    <= 1'b0;
            p1_q           <= '0;
            p2_q           <= '0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            start_d        <= bus.start;
            ball_reset_q   <= 1'b0;
            paddle_reset_q <= 1'b0;
            move_tick_q    <= (st == PLAY) & tick & ~bus.pause;

            case (st)
                IDLE: begin
                    if (start_edge) begin
                        st             <= SERVE;
                        ball_reset_q   <= 1'b1;
                        paddle_reset_q <= 1'b1;
                        serve_dir_q    <= 1'b0;
                        hold           <= '0;
                    end
                end

                SERVE: begin
                    if (tick && !bus.pause) begin
                        if (hold_last) begin
                            st <= PLAY;
                        end else begin
                            hold <= hold + 8'd1;
                        end
                    end
                end

                PLAY: begin
                    // A simultaneous double miss is a dead ball: re-serve without scoring.
                    if (!bus.pause) begin
                        if (bus.miss_left && bus.miss_right) begin
                            st           <= SERVE;
                            ball_reset_q <= 1'b1;
                            hold         <= '0;
                        end else if (bus.miss_left) begin
                            p2_q        <= p2_inc;
                            serve_dir_q <= 1'b1;
                            if (p2_inc == 4'(WIN_SCORE)) begin
                                st          <= OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b1;
                            end else begin
                                st           <= SERVE;
                                ball_reset_q <= 1'b1;
                                hold         <= '0;
                            end
                        end else if (bus.miss_right) begin
                            p1_q        <= p1_inc;
                            serve_dir_q <= 1'b0;
                            if (p1_inc == 4'(WIN_SCORE)) begin
                                st          <= OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b0;
                            end else begin
                                st           <= SERVE;
                                ball_reset_q <= 1'b1;
                                hold         <= '0;
                            end
                        end
                    end
                end

                OVER: begin
                    if (start_edge) begin
                        st             <= SERVE;
                        p1_q           <= '0;
                        p2_q           <= '0;
                        winner_q       <= 1'b0;
                        game_over_q    <= 1'b0;
                        ball_reset_q   <= 1'b1;
                        paddle_reset_q <= 1'b1;
                        serve_dir_q    <= 1'b0;
                        hold           <= '0;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

    assign bus.move_tick    = move_tick_q;
    assign bus.ball_reset   = ball_reset_q;
    assign bus.paddle_reset = paddle_reset_q;
    assign bus.serve_dir    = serve_dir_q;
    assign bus.p1_score     = p1_q;
    assign bus.p2_score     = p2_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;
    assign bus.state        = st;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: game-rule reference model compared every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_pong_game_sequencer;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int WS = 3;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    pong_game_sequencer_if bus();

    pong_game_sequencer #(
        .TICK_DIV(TD),
        .SERVE_TICKS(ST),
        .WIN_SCORE(WS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int passed = 0;
    int total  = 0;

    // Reference model: game phase plus counts, advanced once per clock edge.
    int edges      = 0;
    int m_phase    = 0;
    int m_served   = 0;
    int m_p1       = 0;
    int m_p2       = 0;
    int m_dir      = 0;
    int m_over     = 0;
    int m_win      = 0;
    int m_mt       = 0;
    int m_br       = 0;
    int m_pr       = 0;
    int m_startprv = 0;

    function automatic logic [15:0] dut_vec();
        return {bus.move_tick, bus.ball_reset, bus.paddle_reset, bus.serve_dir,
                bus.p1_score, bus.p2_score, bus.game_over, bus.winner, bus.state};
    endfunction

    function automatic logic [15:0] model_vec();
        return {1'(m_mt), 1'(m_br), 1'(m_pr), 1'(m_dir), 4'(m_p1), 4'(m_p2),
                1'(m_over), 1'(m_win), 2'(m_phase)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic model_clear();
        edges = 0; m_phase = 0; m_served = 0; m_p1 = 0; m_p2 = 0; m_dir = 0;
        m_over = 0; m_win = 0; m_mt = 0; m_br = 0; m_pr = 0; m_startprv = 0;
    endtask

    task automatic new_serve(input int full);
        m_phase = 1; m_served = 0; m_br = 1;
        if (full != 0) begin
            m_pr = 1; m_dir = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0;
        end
    endtask

    task automatic model_step();
        bit tick, sedge, ml, mr, pz;
        tick  = (edges % TD) == TD - 1;
        edges++;
        sedge = bus.start && (m_startprv == 0);
        m_startprv = bus.start;
        ml = bus.miss_left; mr = bus.miss_right; pz = bus.pause;
        m_mt = 0; m_br = 0; m_pr = 0;
        case (m_phase)
            0: if (sedge) new_serve(1);
            1: if (tick && !pz) begin
                m_served++;
                if (m_served == ST) m_phase = 2;
            end
            2: begin
                m_mt = (tick && !pz) ? 1 : 0;
                if (!pz) begin
                    if (ml && mr) new_serve(0);
                    else if (ml || mr) begin
                        if (ml) begin m_p2++; m_dir = 1; end
                        else    begin m_p1++; m_dir = 0; end
                        if (m_p1 == WS || m_p2 == WS) begin
                            m_phase = 3; m_over = 1; m_win = ml ? 1 : 0;
                        end else new_serve(0);
                    end
                end
            end
            default: if (sedge) new_serve(1);
        endcase
    endtask

    always @(negedge RESET_N) model_clear();

    always @(posedge CLOCK_50) begin
        if (RESET_N) begin
            model_step();
            #1;
            if (RESET_N) check("outputs", dut_vec(), model_vec());
        end
    end

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (bus.state != 2'(s) && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        lit("wait_state", bus.state, s);
    endtask

    task automatic pulse(input logic ml, input logic mr);
        bus.miss_left = ml;
        bus.miss_right = mr;
        @(negedge CLOCK_50);
        bus.miss_left = 1'b0;
        bus.miss_right = 1'b0;
    endtask

    initial begin
        int n;
        int mts;
        bus.start = 1'b0; bus.pause = 1'b0; bus.miss_left = 1'b0; bus.miss_right = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_values", dut_vec(), 16'h0000);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        bus.start = 1'b1;
        @(negedge CLOCK_50);
        lit("start_state", bus.state, 1);
        lit("start_ball_reset", bus.ball_reset, 1);
        lit("start_paddle_reset", bus.paddle_reset, 1);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        lit("ball_reset_width", bus.ball_reset, 0);

        wait_state(2, 40);
        n = 0;
        while (!bus.move_tick && n < 20) begin @(negedge CLOCK_50); n++; end
        lit("first_move_gap", n, 4);
        @(negedge CLOCK_50);
        n = 1;
        while (!bus.move_tick && n < 20) begin @(negedge CLOCK_50); n++; end
        lit("move_period", n, 4);

        pulse(1'b0, 1'b1);
        lit("mr_p1", bus.p1_score, 1);
        lit("mr_dir", bus.serve_dir, 0);
        lit("mr_ball_reset", bus.ball_reset, 1);
        lit("mr_state", bus.state, 1);

        wait_state(2, 40);
        pulse(1'b1, 1'b0);
        lit("ml_p2", bus.p2_score, 1);
        lit("ml_dir", bus.serve_dir, 1);

        wait_state(2, 40);
        pulse(1'b1, 1'b1);
        lit("both_p1", bus.p1_score, 1);
        lit("both_p2", bus.p2_score, 1);
        lit("both_ball_reset", bus.ball_reset, 1);
        lit("both_state", bus.state, 1);
        pulse(1'b1, 1'b0);
        lit("serve_miss_ignored", bus.p2_score, 1);

        wait_state(2, 40);
        bus.pause = 1'b1;
        mts = 0;
        for (int i = 0; i < 20; i++) begin
            bus.miss_left = (i == 5);
            @(negedge CLOCK_50);
            mts += int'(bus.move_tick);
        end
        bus.miss_left = 1'b0;
        lit("pause_no_move", mts, 0);
        lit("pause_miss_ignored", bus.p2_score, 1);
        bus.pause = 1'b0;

        pulse(1'b0, 1'b1);
        bus.pause = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        lit("serve_frozen", bus.state, 1);
        bus.pause = 1'b0;
        wait_state(2, 40);

        bus.start = 1'b1;
        pulse(1'b1, 1'b0);
        lit("p2_two", bus.p2_score, 2);
        wait_state(2, 40);
        pulse(1'b1, 1'b0);
        lit("over_state", bus.state, 3);
        lit("over_flag", bus.game_over, 1);
        lit("over_winner", bus.winner, 1);
        lit("over_no_ball_reset", bus.ball_reset, 0);
        repeat (10) @(negedge CLOCK_50);
        lit("held_start_no_restart", bus.state, 3);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        lit("restart_state", bus.state, 1);
        lit("restart_p1", bus.p1_score, 0);
        lit("restart_p2", bus.p2_score, 0);
        lit("restart_over", bus.game_over, 0);
        bus.start = 1'b0;

        repeat (3000) begin
            @(negedge CLOCK_50);
            bus.start      = ($urandom_range(39) == 0);
            if ($urandom_range(49) == 0) bus.pause = ~bus.pause;
            bus.miss_left  = ($urandom_range(14) == 0);
            bus.miss_right = ($urandom_range(14) == 0);
        end
        bus.start = 1'b0; bus.pause = 1'b0; bus.miss_left = 1'b0; bus.miss_right = 1'b0;

        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        wait_state(2, 40);
        pulse(1'b0, 1'b1);
        wait_state(2, 40);
        pulse(1'b0, 1'b1);
        wait_state(2, 40);
        pulse(1'b1, 1'b0);
        wait_state(2, 40);
        lit("pre_reset_p1", bus.p1_score, 2);
        lit("pre_reset_p2", bus.p2_score, 1);
        bus.start = 1'b1;
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset", dut_vec(), 16'h0000);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        lit("held_start_serve", bus.state, 1);
        lit("held_start_paddle", bus.paddle_reset, 1);
        bus.start = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Central game-flow controller for the 1280x1024 Pong design. It replaces the divided-clock scheme with single-clock enables: it generates the movement strobe that advances the ball and paddle registers. It also sequences the game through idle, serve, play and game-over phases, owns both player scores, and issues ball/paddle reset pulses. It sits between the ball/paddle position datapath, which supplies border-miss pulses and consumes the strobe and resets, and the score decoders and LEDs.

## Interface
Parameters:
- TICK_DIV, default 1048576: movement strobe period, in CLOCK_50 cycles (≥2).
- SERVE_TICKS, default 60: strobe periods the ball is held before a serve (1..255).
- WIN_SCORE, default 10: points needed to win (1..15).

Ports:
- CLOCK_50  in  1  sole clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  level input, internally edge-detected; a rising edge starts or restarts a game.
- pause  in  1  level input; freezes play and the serve countdown.
- miss_left  in  1  one-cycle pulse: ball crossed the left border (point to P2).
- miss_right  in  1  one-cycle pulse: ball crossed the right border (point to P1).
- move_tick  out  1  one-cycle movement enable for ball and paddle logic.
- ball_reset  out  1  one-cycle pulse: re-centre the ball to (640,512).
- paddle_reset  out  1  one-cycle pulse: paddles to y=500.
- serve_dir  out  1  0 = serve toward P2 (right), 1 = toward P1 (left).
- p1_score  out  4  P1 points.
- p2_score  out  4  P2 points.
- game_over  out  1  high while in OVER.
- winner  out  1  0 = P1, 1 = P2; valid while game_over is high.
- state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- Tick counter: free-running, width clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps. Internal tick is true when the count is TICK_DIV-1. It runs in every state.
- Start edge: start_d is a registered copy of start. The edge is start & ~start_d.
- IDLE:
  - Scores are 0.
  - A start edge → SERVE, with ball_reset=1 and paddle_reset=1 for one cycle, serve_dir=0, and the hold counter cleared.
- SERVE:
  - The hold counter increments on each tick while pause=0.
  - On a tick with hold = SERVE_TICKS-1 (and pause=0) → PLAY.
  - move_tick stays low.
- PLAY:
  - move_tick = tick & ~pause.
  - With pause=0:
    - miss_left alone: p2_score+1, serve_dir=1.
    - miss_right alone: p1_score+1, serve_dir=0.
    - Both in the same cycle: no score change, serve_dir unchanged, ball_reset, → SERVE.
  - After a single miss: if the incremented score equals WIN_SCORE → OVER, winner set, no ball_reset. Otherwise → SERVE with ball_reset=1 and the hold counter cleared.
  - While pause=1, misses are ignored.
- OVER:
  - Scores and winner are held.
  - A start edge → clear scores, clear winner, ball_reset=1, paddle_reset=1, serve_dir=0 → SERVE.
- Misses in IDLE, SERVE and OVER are ignored.
- A start edge in SERVE or PLAY is ignored.
- Scores never exceed WIN_SCORE and never wrap.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Reset values: state=IDLE, p1_score=0, p2_score=0, move_tick=0, ball_reset=0, paddle_reset=0, serve_dir=0, game_over=0, winner=0. The tick counter, hold counter and start_d are also 0.
- Because start_d resets to 0, a start held high across reset release produces an edge on the first clock.
- move_tick is high for exactly one cycle: the cycle after the counter reads TICK_DIV-1. Its period is TICK_DIV cycles.
- Miss sampled at edge N: score, state, serve_dir and ball_reset update at edge N. They are visible during cycle N+1. ball_reset drops at edge N+1.
- Start edge detected at edge N: state=SERVE and the reset pulses are visible in cycle N+1, one cycle wide.
- The SERVE→PLAY transition occurs on the edge sampling the SERVE_TICKS-th tick after entry. The first move_tick comes TICK_DIV cycles later.
- game_over is asserted in the same cycle state reads OVER.
- An asynchronous reset mid-game returns to IDLE immediately; in-flight pulses are dropped.

## Test plan
With TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3:
- Reset, then start pulse → one cycle later state=1, ball_reset=1, paddle_reset=1 for one cycle. After 2 ticks, state=2 and move_tick pulses every 4 cycles.
- In PLAY, miss_right ×1 → p1_score=1, serve_dir=0, ball_reset one cycle, state=1. miss_left → p2_score=1, serve_dir=1.
- miss_left and miss_right in the same cycle → scores unchanged, ball_reset=1, state=1. Misses in SERVE → ignored.
- pause=1 in PLAY for 20 cycles → no move_tick, misses ignored. pause=1 in SERVE → the hold countdown freezes and resumes on release.
- P2 reaches 3 → state=3, game_over=1, winner=1, no ball_reset. Start held high → no restart until a new rising edge, which clears scores and gives state=1.
- RESET_N low mid-PLAY with scores 2-1 → all outputs take their reset values asynchronously. Start held high across release → SERVE entered on the first edge.
